// File: rtl/csr_timer_irq.sv
// Countdown timers and synchronised hardware interrupt lines behind a small CSR window.
// Provides read data and hit for its own addresses and drives the interrupt pending vectors.
module csr_timer_irq #(
    parameter int          NTIMER   = 1,
    parameter int          TIMER_W  = 32,
    parameter int          HWI_N    = 8,
    parameter logic [7:0]  HWI_EDGE = 8'h00,
    parameter logic [13:0] CSR_BASE = 14'h41
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                csr_we,
    input  logic [13:0]         csr_num,
    input  logic [31:0]         csr_wmask,
    input  logic [31:0]         csr_wvalue,
    output logic [31:0]         csr_rvalue,
    output logic                csr_hit,
    input  logic [HWI_N-1:0]    hw_int_in,
    output logic [NTIMER-1:0]   timer_int,
    output logic [HWI_N-1:0]    hwi_pend
);
    localparam logic [13:0]        HWISTAT_OFF = 14'(4 * NTIMER);
    localparam logic [13:0]        HWICLR_OFF  = 14'(4 * NTIMER + 1);
    localparam logic [HWI_N-1:0]   EDGE_MASK   = HWI_EDGE[HWI_N-1:0];
    localparam logic [TIMER_W-1:0] CNT_ONE     = 1;

    logic                w_in_win;
    logic [13:0]         w_off;
    logic [NTIMER-1:0]   w_grp_sel;
    logic [TIMER_W-1:0]  w_cfg_rd [NTIMER];
    logic [TIMER_W-1:0]  w_cnt_rd [NTIMER];

    assign w_in_win = (csr_num >= CSR_BASE);
    assign w_off    = csr_num - CSR_BASE;

    genvar gi;
    generate
        for (gi = 0; gi < NTIMER; gi++) begin : g_timer
            logic [TIMER_W-1:0] r_cfg;
            logic [TIMER_W-1:0] r_count;
            logic               r_armed;
            logic               r_fire;
            logic               r_tint;
            logic [TIMER_W-1:0] w_cfg_new;
            logic               w_cfg_we;
            logic               w_clr;

            assign w_grp_sel[gi] = w_in_win && (w_off[13:2] == 12'(gi));
            assign w_cfg_we  = csr_we && w_grp_sel[gi] && (w_off[1:0] == 2'd0);
            assign w_clr     = csr_we && w_grp_sel[gi] && (w_off[1:0] == 2'd3)
                               && csr_wmask[0] && csr_wvalue[0];
            assign w_cfg_new = (csr_wmask[TIMER_W-1:0] & csr_wvalue[TIMER_W-1:0])
                             | (~csr_wmask[TIMER_W-1:0] & r_cfg);

            // Expiry is registered once more, so timer_int rises the edge after the reload.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cfg   <= '0;
                    r_count <= '1;
                    r_armed <= 1'b0;
                    r_fire  <= 1'b0;
                    r_tint  <= 1'b0;
                end else begin
                    r_fire <= 1'b0;
                    if (w_cfg_we) begin
                        r_cfg <= w_cfg_new;
                        if (w_cfg_new[0]) begin
                            r_count <= {w_cfg_new[TIMER_W-1:2], 2'b00};
                            r_armed <= 1'b1;
                        end
                    end else if (r_cfg[0] && r_armed) begin
                        if (r_count != '0) begin
                            r_count <= r_count - CNT_ONE;
                        end else begin
                            r_fire <= 1'b1;
                            if (r_cfg[1]) begin
                                r_count <= {r_cfg[TIMER_W-1:2], 2'b00};
                            end else begin
                                r_count <= '1;
                                r_armed <= 1'b0;
                            end
                        end
                    end
                    r_tint <= r_fire | (r_tint & ~w_clr);
                end
            end

            assign w_cfg_rd[gi]  = r_cfg;
            assign w_cnt_rd[gi]  = r_count;
            assign timer_int[gi] = r_tint;
        end
    endgenerate

    logic [HWI_N-1:0] r_s1;
    logic [HWI_N-1:0] r_s2;
    logic [HWI_N-1:0] r_s3;
    logic [HWI_N-1:0] r_latch;
    logic [HWI_N-1:0] w_hclr;

    assign w_hclr = (csr_we && w_in_win && (w_off == HWICLR_OFF))
                  ? (csr_wmask[HWI_N-1:0] & csr_wvalue[HWI_N-1:0]) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_latch <= '0;
        end else begin
            r_s1    <= hw_int_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_latch <= EDGE_MASK & ((r_s2 & ~r_s3) | (r_latch & ~w_hclr));
        end
    end

    assign hwi_pend = (EDGE_MASK & r_latch) | (~EDGE_MASK & r_s2);

    always_comb begin
        csr_rvalue = '0;
        csr_hit    = 1'b0;
        for (int n = 0; n < NTIMER; n++) begin
            if (w_grp_sel[n]) begin
                case (w_off[1:0])
                    2'd0: begin csr_hit = 1'b1; csr_rvalue = 32'(w_cfg_rd[n]); end
                    2'd1: begin csr_hit = 1'b1; csr_rvalue = 32'(w_cnt_rd[n]); end
                    2'd3: csr_hit = 1'b1;
                    default: ;
                endcase
            end
        end
        if (w_in_win && (w_off == HWISTAT_OFF)) begin
            csr_hit    = 1'b1;
            csr_rvalue = 32'(hwi_pend);
        end
        if (w_in_win && (w_off == HWICLR_OFF)) begin
            csr_hit = 1'b1;
        end
    end
endmodule

// File: tb/tb_csr_timer_irq.sv
// Directed bench for csr_timer_irq: stimulus pushes expectations, a negedge monitor pops and checks.
module tb_csr_timer_irq;
    localparam logic [13:0] TCFG0   = 14'h41;
    localparam logic [13:0] TVAL0   = 14'h42;
    localparam logic [13:0] TICLR0  = 14'h44;
    localparam logic [13:0] TCFG1   = 14'h45;
    localparam logic [13:0] TVAL1   = 14'h46;
    localparam logic [13:0] TICLR1  = 14'h48;
    localparam logic [13:0] HWISTAT = 14'h49;
    localparam logic [13:0] HWICLR  = 14'h4A;
    localparam int K_RD = 0;
    localparam int K_TI = 1;
    localparam int K_HP = 2;

    logic        clk;
    logic        rst;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [31:0] csr_rvalue;
    logic        csr_hit;
    logic [7:0]  hw_int_in;
    logic [1:0]  timer_int;
    logic [7:0]  hwi_pend;

    csr_timer_irq #(
        .NTIMER(2), .TIMER_W(32), .HWI_N(8), .HWI_EDGE(8'h01), .CSR_BASE(14'h41)
    ) dut (
        .clk(clk), .rst(rst), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
        .csr_hit(csr_hit), .hw_int_in(hw_int_in), .timer_int(timer_int), .hwi_pend(hwi_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           q_kind [$];
    logic [32:0]  q_exp  [$];
    string        q_name [$];
    logic         chk_valid;
    int           n_checks = 0;
    int           n_pass = 0;

    int           m_kind;
    logic [32:0]  m_exp;
    logic [32:0]  m_act;
    string        m_name;

    always @(negedge clk) begin
        if (chk_valid) begin
            while (q_kind.size() > 0) begin
                m_kind = q_kind.pop_front();
                m_exp  = q_exp.pop_front();
                m_name = q_name.pop_front();
                case (m_kind)
                    K_RD:    m_act = {csr_hit, csr_rvalue};
                    K_TI:    m_act = 33'(timer_int);
                    default: m_act = 33'(hwi_pend);
                endcase
                n_checks++;
                if (m_act !== m_exp)
                    $display("FAIL %s: got %h expected %h", m_name, m_act, m_exp);
                else begin
                    n_pass++;
                    $display("ok   %s: %h", m_name, m_act);
                end
            end
        end
    end

    task automatic check_now(input logic [32:0] act, input logic [32:0] exp, input string n);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", n, act, exp);
        else begin
            n_pass++;
            $display("ok   %s: %h", n, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        csr_we    = 1'b0;
        chk_valid = 1'b0;
    endtask

    task automatic push(input int k, input logic [32:0] e, input string n);
        q_kind.push_back(k);
        q_exp.push_back(e);
        q_name.push_back(n);
        chk_valid = 1'b1;
    endtask

    task automatic rd(input logic [13:0] a, input logic h, input logic [31:0] v, input string n);
        csr_num = a;
        push(K_RD, {h, v}, n);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] v);
        csr_we     = 1'b1;
        csr_num    = a;
        csr_wmask  = m;
        csr_wvalue = v;
    endtask

    initial begin
        rst = 1'b1; csr_we = 1'b0; csr_num = '0; csr_wmask = '0; csr_wvalue = '0;
        hw_int_in = '0; chk_valid = 1'b0;
        step(); step();
        rst = 1'b0;

        check_now(33'(timer_int), 33'h0, "rst_ti_now");
        check_now(33'(hwi_pend), 33'h0, "rst_hp_now");

        // Reset defaults and address decode
        rd(TVAL0, 1'b1, 32'hFFFF_FFFF, "rst_tval0"); push(K_TI, 0, "rst_ti"); push(K_HP, 0, "rst_hp"); step();
        rd(TCFG0, 1'b1, 32'h0, "rst_tcfg0"); step();
        rd(TVAL1, 1'b1, 32'hFFFF_FFFF, "rst_tval1"); step();
        rd(TICLR0, 1'b1, 32'h0, "ticlr_read"); step();
        rd(14'h43, 1'b0, 32'h0, "hole_grp0"); step();
        rd(14'h4B, 1'b0, 32'h0, "hole_h2"); step();
        rd(14'h4C, 1'b0, 32'h0, "above_win"); step();
        rd(14'h40, 1'b0, 32'h0, "below_win"); step();
        rd(HWICLR, 1'b1, 32'h0, "hwiclr_read"); step();
        wr(TVAL0, 32'hFFFF_FFFF, 32'h1234); step();
        rd(TVAL0, 1'b1, 32'hFFFF_FFFF, "tval_readonly"); step();

        // One-shot INITV=2
        wr(TCFG0, 32'hFFFF_FFFF, 32'h9); step();
        for (int i = 8; i >= 0; i--) begin
            rd(TVAL0, 1'b1, 32'(i), "os_tval"); push(K_TI, 0, "os_ti_low"); step();
        end
        rd(TVAL0, 1'b1, 32'hFFFF_FFFF, "os_expire"); push(K_TI, 0, "os_ti_edge9"); step();
        rd(TVAL0, 1'b1, 32'hFFFF_FFFF, "os_hold"); push(K_TI, 1, "os_ti_rise"); step();
        rd(TVAL0, 1'b1, 32'hFFFF_FFFF, "os_stopped"); push(K_TI, 1, "os_ti_hold"); step();
        check_now(33'(timer_int), 33'h1, "os_ti_expired");
        csr_num = TVAL0; #1;
        check_now({csr_hit, csr_rvalue}, {1'b1, 32'hFFFF_FFFF}, "os_tval_expired");
        wr(TICLR0, 32'hFFFF_FFFF, 32'h1); step();
        rd(TVAL0, 1'b1, 32'hFFFF_FFFF, "os_after_clr"); push(K_TI, 0, "os_ticlr"); step();

        // Freeze and re-enable, INITV=3
        wr(TCFG0, 32'hFFFF_FFFF, 32'hD); step();
        for (int i = 0; i < 3; i++) begin
            rd(TVAL0, 1'b1, 32'(12 - i), "fz_run"); step();
        end
        wr(TCFG0, 32'h1, 32'h0); step();
        for (int i = 0; i < 3; i++) begin
            rd(TVAL0, 1'b1, 32'd9, "fz_hold"); step();
        end
        rd(TCFG0, 1'b1, 32'hC, "fz_cfg"); step();
        wr(TCFG0, 32'h1, 32'h1); step();
        rd(TVAL0, 1'b1, 32'd12, "fz_reload"); step();
        rd(TVAL0, 1'b1, 32'd11, "fz_resume"); step();
        rd(TCFG0, 1'b1, 32'hD, "fz_cfg_en"); step();

        // Asynchronous reset mid-count
        rst = 1'b1;
        rd(TVAL0, 1'b1, 32'hFFFF_FFFF, "async_rst_tval"); step();
        step();
        rst = 1'b0;
        rd(TVAL0, 1'b1, 32'hFFFF_FFFF, "rst_no_resume"); step();
        step();
        rd(TVAL0, 1'b1, 32'hFFFF_FFFF, "rst_still_idle"); step();
        rd(TCFG0, 1'b1, 32'h0, "rst_cfg_clear"); step();

        // Periodic timer 1, INITV=1
        wr(TCFG1, 32'hFFFF_FFFF, 32'h7); step();
        for (int e = 0; e <= 5; e++) begin
            rd(TVAL1, 1'b1, 32'(4 - (e % 5)), "per_tval"); push(K_TI, 0, "per_ti_low"); step();
        end
        rd(TVAL1, 1'b1, 32'd3, "per_tval_e6"); push(K_TI, 2, "per_ti_set"); step();
        push(K_TI, 2, "per_ti_hold"); wr(TICLR1, 32'hFFFF_FFFF, 32'h1); step();
        rd(TVAL1, 1'b1, 32'd1, "per_tval_e8"); push(K_TI, 0, "per_ticlr"); step();
        rd(TVAL1, 1'b1, 32'd0, "per_tval_e9"); push(K_TI, 0, "per_ti_e9"); step();
        push(K_TI, 0, "per_ti_e10"); wr(TICLR1, 32'hFFFF_FFFF, 32'h1); step();
        rd(TVAL1, 1'b1, 32'd3, "per_tval_e11"); push(K_TI, 2, "per_set_wins"); step();
        rd(TVAL0, 1'b1, 32'hFFFF_FFFF, "t0_idle"); push(K_TI, 2, "per_ti_e12"); step();

        // Level line 3
        for (int c = 0; c < 8; c++) begin
            if (c == 0) hw_int_in[3] = 1'b1;
            if (c == 4) hw_int_in[3] = 1'b0;
            rd(HWISTAT, 1'b1, (c >= 2 && c <= 5) ? 32'h8 : 32'h0, "lvl_stat");
            push(K_HP, (c >= 2 && c <= 5) ? 33'h8 : 33'h0, "lvl_pend");
            step();
        end
        hw_int_in[3] = 1'b1;
        step(); step(); step();
        wr(HWICLR, 32'hFFFF_FFFF, 32'h8); step();
        push(K_HP, 33'h8, "lvl_ignores_clr"); step();
        hw_int_in[3] = 1'b0;
        step(); step(); step();

        // Edge line 0
        for (int c = 0; c < 6; c++) begin
            if (c == 0) hw_int_in[0] = 1'b1;
            if (c == 1) hw_int_in[0] = 1'b0;
            push(K_HP, (c >= 3) ? 33'h1 : 33'h0, "edge_latch"); step();
        end
        rd(HWISTAT, 1'b1, 32'h1, "edge_stat"); step();
        wr(HWICLR, 32'h0, 32'h1); step();
        push(K_HP, 33'h1, "edge_mask0_keeps"); step();
        wr(HWICLR, 32'hFFFF_FFFF, 32'h1); step();
        push(K_HP, 33'h0, "edge_clr"); step();
        hw_int_in[0] = 1'b1; push(K_HP, 33'h0, "edge_pre1"); step();
        hw_int_in[0] = 1'b0; push(K_HP, 33'h0, "edge_pre2"); step();
        push(K_HP, 33'h0, "edge_pre3"); wr(HWICLR, 32'hFFFF_FFFF, 32'h1); step();
        push(K_HP, 33'h1, "edge_set_wins"); step();
        push(K_HP, 33'h1, "edge_set_holds"); step();

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/csr_timer_irq.md
# csr_timer_irq

Parametrised timer and interrupt-source unit that succeeds the single fixed 32-bit timer and constant-zero interrupt inputs inside the CSR file. It provides `NTIMER` independent countdown timers of width `TIMER_W`, plus `HWI_N` synchronised hardware interrupt lines with per-line level/edge mode. It sits beside `csr`: it decodes the same CSR write port, returns read data for its own addresses, and drives the pending vector that feeds ESTAT.IS and `has_int`.

## Interface
Parameters:
- `NTIMER`, 1: number of timers (1..4).
- `TIMER_W`, 32: counter width (8..32).
- `HWI_N`, 8: hardware interrupt lines (1..8).
- `HWI_EDGE`, 8'h00: bit i = 1 makes line i edge-triggered (latched); 0 makes it level.
- `CSR_BASE`, 14'h41: base CSR number of the register window.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `csr_we` in 1: CSR write enable.
- `csr_num` in 14: CSR number, shared by read and write.
- `csr_wmask` in 32: write mask.
- `csr_wvalue` in 32: write data.
- `csr_rvalue` out 32: combinational read data; 0 on a miss.
- `csr_hit` out 1: combinational; `csr_num` falls inside this block's map.
- `hw_int_in` in HWI_N: asynchronous interrupt lines.
- `timer_int` out NTIMER: timer pending bits.
- `hwi_pend` out HWI_N: hardware pending bits.

## Operation
Register map (n = 0..NTIMER-1, H = CSR_BASE+4·NTIMER):
- TCFG(n) at CSR_BASE+4n.
  - bit0 EN, bit1 PERIODIC, bits[TIMER_W-1:2] INITV.
  - Upper bits read 0.
  - Masked write: new = wmask&wvalue | ~wmask&old.
- TVAL(n) at CSR_BASE+4n+1: read-only current count, zero-extended. Writes are ignored.
- TICLR(n) at CSR_BASE+4n+3: reads 0. A write with wmask[0]&wvalue[0] clears `timer_int[n]`.
- HWISTAT at H: read-only, {0, hwi_pend}.
- HWICLR at H+1: reads 0. A write with wmask&wvalue bit i set clears the edge latch of line i. Level lines ignore this write.

Timer n state: count[TIMER_W-1:0], armed.
- TCFG write whose masked EN is 1: count ← {new INITV, 2'b00}, armed ← 1. This takes priority over any decrement.
- TCFG write whose masked EN is 0: count frozen. armed is unchanged.
- When EN and armed and count≠0: count ← count−1.
- When EN and armed and count==0:
  - `timer_int[n]` ← 1.
  - If PERIODIC: count ← {INITV, 2'b00}.
  - Otherwise: count ← all-ones and armed ← 0. The timer stays stopped until TCFG is rewritten.
- Set and TICLR clear in the same cycle: set wins.

Hardware line i:
- Passes through a 2-flop synchroniser (s2), followed by a history flop (s3).
- Level line: `hwi_pend[i]` = s2.
- Edge line: the latch is set when s2 & ~s3. It is cleared by HWICLR. Set wins over clear in the same cycle.

Decode and read:
- Addresses inside the window but unmapped (offset +2 of each timer group, H+2, H+3) give `csr_hit` = 0 and read 0.
- Addresses above H+1 give `csr_hit` = 0 and read 0.

## Timing
Reset values (asynchronous, take effect immediately):
- EN, PERIODIC, INITV, armed = 0.
- count = all-ones.
- `timer_int`, `hwi_pend`, synchroniser flops and edge latches = 0.

General rules:
- A CSR write takes effect at the next `clk` edge. A read in the same cycle returns the old value.
- Timer with INITV = k and EN: the count is 4k at edge 0 (the write). `timer_int` rises at edge 4k+2.
- Periodic period = 4k+1 cycles. With INITV = 0 and PERIODIC, the timer fires every cycle.

Hardware interrupt latency:
- Level line: `hw_int_in` high before edge 1 makes `hwi_pend` high after edge 2. Deassertion propagates with the same 2-cycle delay.
- Edge line: the latch sets at edge 3 after the rising input and stays set until cleared.

Reset asserted mid-count: all state returns to reset values at once, and the count does not resume after release.

## Test plan
1. Reset defaults: after `rst`, read TVAL(0) → 0xFFFFFFFF, TCFG(0) → 0, `timer_int` = 0, `hwi_pend` = 0.
2. One-shot: write TCFG(0) = 0x00000009 (INITV 2, EN) → TVAL reads 8,7,…,0. `timer_int[0]` rises 10 edges after the write edge, then TVAL = 0xFFFFFFFF and holds. TICLR write 1 → `timer_int[0]` = 0 next cycle.
3. Periodic, with NTIMER = 2 and TIMER_W = 16: TCFG(1) = 0x0007 (INITV 1, PERIODIC, EN) → count reloads to 4 after 0. `timer_int[1]` is re-set every 5 cycles. A TICLR issued in the same cycle as a re-fire leaves `timer_int[1]` = 1. Timer 0 stays idle.
4. Freeze: mid-count, write TCFG with wmask = 0x1 and wvalue = 0 → TVAL holds its value. Rewrite EN = 1 → the count reloads from INITV·4.
5. Level line 3: pulse `hw_int_in[3]` high for 4 cycles → `hwi_pend[3]` high for 4 cycles, delayed by 2 cycles. HWISTAT reads 0x8 during that window.
6. Edge line 0 (HWI_EDGE = 8'h01): a 1-cycle pulse → `hwi_pend[0]` is latched 3 edges later and stays high. HWICLR write 0x1 clears it. A new edge arriving in the clear cycle keeps it at 1.
